// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: single-clock UART frame transmitter.
// Pops bytes from a show-ahead TX FIFO and sends each one as a frame:
// a start bit, DATA_SIZE data bits LSB first, an optional parity bit,
// then STOP_BITS stop bits. Bit timing comes from an internal baud counter.
//
// Ports:
//   clk             system clock
//   reset_n         asynchronous active-low reset
//   enable          1 = allowed to start new frames
//   fifo_empty      TX FIFO empty flag
//   fifo_data       TX FIFO head word (show-ahead)
//   fifo_read       one-cycle pop strobe (combinational)
//   serial_data_out UART line, idle high (registered)
//   tx_busy         frame in progress (registered)
//   tx_done         pulse in the final cycle of the last stop bit (registered)
module uart_tx_serializer #(
  parameter int DATA_SIZE  = 8,
  parameter int SYS_FREQ   = 100000000,
  parameter int BAUD_RATE  = 9600,
  parameter int BAUD_DVSR  = SYS_FREQ / BAUD_RATE,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 fifo_empty,
  input  logic [DATA_SIZE-1:0] fifo_data,
  output logic                 fifo_read,
  output logic                 serial_data_out,
  output logic                 tx_busy,
  output logic                 tx_done
);
  localparam int BW   = $clog2(BAUD_DVSR);
  localparam int BITW = $clog2(DATA_SIZE + 1);

  localparam logic [BW-1:0]   BAUD_LAST = BW'(BAUD_DVSR - 1);
  localparam logic [BW-1:0]   BAUD_PRE  = BW'(BAUD_DVSR - 2);
  localparam logic [BITW-1:0] DATA_LAST = BITW'(DATA_SIZE - 1);
  localparam logic [BITW-1:0] STOP_LAST = BITW'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               r_state;
  logic [BW-1:0]        r_baud;
  logic [BITW-1:0]      r_bit;
  logic [DATA_SIZE-1:0] r_shift;
  logic                 r_par;
  logic                 r_sdo;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_tc;
  logic                 w_last_stop;
  logic                 w_capture;
  logic [DATA_SIZE-1:0] w_shift_nx;

  assign w_tc        = (r_baud == BAUD_LAST);
  assign w_last_stop = (r_state == STOP) && w_tc && (r_bit == STOP_LAST);
  // A new frame can start from IDLE or straight out of the last stop cycle,
  // which gives back-to-back frames with no idle gap.
  assign w_capture   = ((r_state == IDLE) || w_last_stop) && enable && !fifo_empty;
  assign fifo_read   = reset_n && w_capture;
  assign w_shift_nx  = r_shift >> 1;

  assign serial_data_out = r_sdo;
  assign tx_busy         = r_busy;
  assign tx_done         = r_done;

  // The line register is loaded with the value of the bit about to start,
  // so every line bit is exactly BAUD_DVSR cycles long.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_sdo   <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      // Registered pulse: armed one cycle ahead so it lands in the final cycle.
      r_done <= (r_state == STOP) && (r_baud == BAUD_PRE) && (r_bit == STOP_LAST);
      if (w_capture) begin
        r_state <= START;
        r_baud  <= '0;
        r_bit   <= '0;
        r_shift <= fifo_data;
        r_par   <= (^fifo_data) ^ (PARITY_ODD != 0);
        r_sdo   <= 1'b0;
        r_busy  <= 1'b1;
      end else if (r_state != IDLE) begin
        if (!w_tc) begin
          r_baud <= r_baud + BW'(1);
        end else begin
          r_baud <= '0;
          case (r_state)
            START: begin
              r_state <= DATA;
              r_bit   <= '0;
              r_sdo   <= r_shift[0];
            end
            DATA: begin
              if (r_bit == DATA_LAST) begin
                r_bit <= '0;
                if (PARITY_EN != 0) begin
                  r_state <= PARITY;
                  r_sdo   <= r_par;
                end else begin
                  r_state <= STOP;
                  r_sdo   <= 1'b1;
                end
              end else begin
                r_bit   <= r_bit + BITW'(1);
                r_shift <= w_shift_nx;
                r_sdo   <= w_shift_nx[0];
              end
            end
            PARITY: begin
              r_state <= STOP;
              r_bit   <= '0;
              r_sdo   <= 1'b1;
            end
            STOP: begin
              if (r_bit == STOP_LAST) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
                r_sdo   <= 1'b1;
              end else begin
                r_bit <= r_bit + BITW'(1);
              end
            end
            default: begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_sdo   <= 1'b1;
            end
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer. Three instances cover the
// configurations: u0 (even parity, 1 stop), u1 (no parity, 2 stops),
// u2 (odd parity, 1 stop). All use BAUD_DVSR = 4, giving 44-cycle frames.
// Frame vectors are 11 bits, bit 0 = start bit, transmitted in index order.
module tb_uart_tx_serializer;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       en0 = 0, en1 = 0, en2 = 0;
  logic [7:0] mem0 [16];
  logic [7:0] mem1 [16];
  logic [7:0] mem2 [16];
  logic [3:0] wr0 = 0, wr1 = 0, wr2 = 0;
  logic [3:0] rd0 = 0, rd1 = 0, rd2 = 0;
  logic       fe0, fe1, fe2;
  logic [7:0] fd0, fd1, fd2;
  logic       frd0, frd1, frd2, sdo0, sdo1, sdo2, bsy0, bsy1, bsy2, dn0, dn1, dn2;

  assign fe0 = (rd0 == wr0);
  assign fe1 = (rd1 == wr1);
  assign fe2 = (rd2 == wr2);
  assign fd0 = mem0[rd0];
  assign fd1 = mem1[rd1];
  assign fd2 = mem2[rd2];

  // show-ahead FIFO models: pop on the read strobe
  always @(posedge clk) begin
    if (frd0) rd0 <= rd0 + 4'd1;
    if (frd1) rd1 <= rd1 + 4'd1;
    if (frd2) rd2 <= rd2 + 4'd1;
  end

  uart_tx_serializer #(.DATA_SIZE(8), .BAUD_DVSR(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
    .clk(clk), .reset_n(reset_n), .enable(en0), .fifo_empty(fe0), .fifo_data(fd0),
    .fifo_read(frd0), .serial_data_out(sdo0), .tx_busy(bsy0), .tx_done(dn0));
  uart_tx_serializer #(.DATA_SIZE(8), .BAUD_DVSR(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u1 (
    .clk(clk), .reset_n(reset_n), .enable(en1), .fifo_empty(fe1), .fifo_data(fd1),
    .fifo_read(frd1), .serial_data_out(sdo1), .tx_busy(bsy1), .tx_done(dn1));
  uart_tx_serializer #(.DATA_SIZE(8), .BAUD_DVSR(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
    .clk(clk), .reset_n(reset_n), .enable(en2), .fifo_empty(fe2), .fifo_data(fd2),
    .fifo_read(frd2), .serial_data_out(sdo2), .tx_busy(bsy2), .tx_done(dn2));

  int   sel = 0;
  logic rd_m, sdo_m, bsy_m, dn_m;
  always_comb begin
    rd_m = frd0; sdo_m = sdo0; bsy_m = bsy0; dn_m = dn0;
    case (sel)
      1: begin rd_m = frd1; sdo_m = sdo1; bsy_m = bsy1; dn_m = dn1; end
      2: begin rd_m = frd2; sdo_m = sdo2; bsy_m = bsy2; dn_m = dn2; end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int k, input logic [7:0] d);
    case (k)
      0: begin mem0[wr0] = d; wr0 = wr0 + 4'd1; end
      1: begin mem1[wr1] = d; wr1 = wr1 + 4'd1; end
      default: begin mem2[wr2] = d; wr2 = wr2 + 4'd1; end
    endcase
  endtask

  // Raise enable of instance k at a falling edge; the pop must be immediate.
  task automatic start(input int k, input string tag);
    @(negedge clk);
    case (k)
      0: en0 = 1;
      1: en1 = 1;
      default: en2 = 1;
    endcase
    #1;
    chk({tag, " start_read"}, rd_m, 1);
  endtask

  // Check one 44-cycle frame cycle by cycle, starting at the next falling edge.
  // drop >= 0 lowers en0 at that frame cycle.
  task automatic frame(input logic [15:0] bits, input string tag, input int drop);
    for (int i = 0; i < 11; i++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (i * 4 + c == drop) en0 = 0;
        chk({tag, " line"}, sdo_m, bits[i]);
        chk({tag, " busy"}, bsy_m, 1);
        chk({tag, " done"}, dn_m, (i == 10 && c == 3) ? 1 : 0);
        if (!(i == 10 && c == 3)) chk({tag, " read"}, rd_m, 0);
      end
    end
  endtask

  initial begin
    reset_n = 0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      sel = k;
      #1;
      chk("rst line", sdo_m, 1);
      chk("rst busy", bsy_m, 0);
      chk("rst done", dn_m, 0);
      chk("rst read", rd_m, 0);
    end
    sel = 0;
    reset_n = 1;

    // 1: single frame, 8'hB3 even parity
    push(0, 8'hB3);
    start(0, "t1");
    frame(16'h766, "t1", -1);
    chk("t1 one_read", rd_m, 0);
    @(negedge clk);
    chk("t1 idle line", sdo_m, 1);
    chk("t1 idle busy", bsy_m, 0);
    chk("t1 idle done", dn_m, 0);
    en0 = 0;

    // 2: back-to-back frames, pops 44 cycles apart
    push(0, 8'hB3); push(0, 8'h5C); push(0, 8'hAE);
    start(0, "t2a");
    frame(16'h766, "t2a", -1);
    chk("t2a next_read", rd_m, 1);
    frame(16'h4B8, "t2b", -1);
    chk("t2b next_read", rd_m, 1);
    frame(16'h75C, "t2c", -1);
    chk("t2c no_read", rd_m, 0);
    @(negedge clk);
    chk("t2 idle busy", bsy_m, 0);

    // 3: empty FIFO with enable high
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      chk("t3 read", rd_m, 0);
      chk("t3 line", sdo_m, 1);
      chk("t3 busy", bsy_m, 0);
    end
    en0 = 0;

    // 4: reset during data bit 3
    push(0, 8'hB3);
    start(0, "t4");
    repeat (18) @(negedge clk);
    chk("t4 in_frame busy", bsy_m, 1);
    chk("t4 bit3 line", sdo_m, 0);
    reset_n = 0;
    #1;
    chk("t4 async line", sdo_m, 1);
    chk("t4 async busy", bsy_m, 0);
    push(0, 8'h5C);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("t4 rst done", dn_m, 0);
      chk("t4 rst read", rd_m, 0);
      chk("t4 rst line", sdo_m, 1);
    end
    reset_n = 1;
    #1;
    chk("t4 release_read", rd_m, 1);
    frame(16'h4B8, "t4", -1);
    chk("t4 no_read", rd_m, 0);
    en0 = 0;

    // 5: no parity, 2 stop bits; odd parity of 8'h00
    sel = 1;
    push(1, 8'h5C);
    start(1, "t5a");
    frame(16'h6B8, "t5a", -1);
    chk("t5a no_read", rd_m, 0);
    en1 = 0;
    sel = 2;
    push(2, 8'h00);
    start(2, "t5b");
    frame(16'h600, "t5b", -1);
    chk("t5b no_read", rd_m, 0);
    en2 = 0;

    // 6: enable dropped mid-frame with a second word queued
    sel = 0;
    @(negedge clk);
    push(0, 8'hB3); push(0, 8'h5C);
    start(0, "t6");
    frame(16'h766, "t6", 20);
    chk("t6 held_read", rd_m, 0);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      chk("t6 gap read", rd_m, 0);
      chk("t6 gap line", sdo_m, 1);
      chk("t6 gap busy", bsy_m, 0);
    end
    @(negedge clk);
    en0 = 1;
    #1;
    chk("t6 reenable_read", rd_m, 1);
    frame(16'h4B8, "t6b", -1);
    chk("t6b no_read", rd_m, 0);
    en0 = 0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
